vga_focus_metric: RTL and testbench



---
 rtl/vga_focus_metric_pkg.sv | 30 +++
 rtl/vga_focus_metric_if.sv | 9 +
 rtl/vga_focus_metric_pixel_counter.sv | 60 ++++++
 rtl/vga_focus_metric.sv | 155 +++++++++++++++
 tb/tb_vga_focus_metric.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_focus_metric_pkg.sv
// Shared types, widths and arithmetic helpers for the focus-metric block.
package vga_focus_pkg;

   // Frame-tracking states: S_SYNC waits for the first frame boundary, S_RUN measures.
   typedef enum logic {
      S_SYNC,
      S_RUN
   } state_t;

   // Coordinate width; matches the H_Cont/V_Cont counters elsewhere in the video path.
   localparam int COORD_W = 13;

   // Working width of the saturating adder; any accumulator up to this width is supported.
   localparam int SUM_W = 64;

   // Adds an 8-bit gradient to an accumulator and clamps the result at 'limit'.
   function automatic logic [SUM_W-1:0] sat_add(
      input logic [SUM_W-1:0] acc,
      input logic [7:0]       d,
      input logic [SUM_W-1:0] limit
   );
      logic [SUM_W:0] sum;
      sum = {1'b0, acc} + {{(SUM_W-7){1'b0}}, d};
      if (sum > {1'b0, limit}) begin
         return limit;
      end
      return sum[SUM_W-1:0];
   endfunction

endpackage

// File: rtl/vga_focus_metric_if.sv
// Video tap bundle: the filtered grayscale stream plus its sync/blank qualifiers.
interface vga_focus_metric_if;
   logic [7:0] iVGA_Gr;
   logic       iVGA_VS;
   logic       iVGA_BLANK_N;

   modport master (output iVGA_Gr, output iVGA_VS, output iVGA_BLANK_N);
   modport slave  (input  iVGA_Gr, input  iVGA_VS, input  iVGA_BLANK_N);
endinterface

// File: rtl/vga_focus_metric_pixel_counter.sv
// Active-area x/y tracker driven by registered blank and vsync; flags over-long lines/frames.
module vga_pixel_counter
   import vga_focus_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic               VGA_CLK,
   input  logic               reset_n,
   input  logic               i_blank_n,
   input  logic               i_vs,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic               o_overrun
);

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT);

   logic               r_blank_prev;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic               r_overrun;
   logic               w_blank_fall;

   assign w_blank_fall = r_blank_prev & ~i_blank_n;

   // Advance x per active pixel, y per line end, restart on vsync; both clamp at the frame size.
   always_ff @(posedge VGA_CLK) begin
      if (!reset_n) begin
         r_blank_prev <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
         r_overrun    <= 1'b0;
      end else begin
         r_blank_prev <= i_blank_n;
         if (!i_vs) begin
            r_x <= '0;
            r_y <= '0;
         end else if (w_blank_fall) begin
            r_x <= '0;
            if (r_y != Y_MAX) begin
               r_y <= r_y + 1'b1;
            end
         end else if (i_blank_n && (r_x != X_MAX)) begin
            r_x <= r_x + 1'b1;
         end
         // An active pixel arriving once a counter is already at its limit means the line
         // or frame is longer than configured; the flag stays set until reset.
         if (i_blank_n && ((r_x == X_MAX) || (r_y == Y_MAX))) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign o_x       = r_x;
   assign o_y       = r_y;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/vga_focus_metric.sv
// Per-frame sharpness metric: sum of |horizontal grayscale gradient| inside a window,
// with peak tracking for the auto-focus search. Observes the stream without altering it.
module vga_focus_metric
   import vga_focus_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int WIN_X0 = 160,
   parameter int WIN_Y0 = 120,
   parameter int WIN_W  = 320,
   parameter int WIN_H  = 240,
   parameter int ACC_W  = 32
) (
   input  logic                VGA_CLK,
   input  logic                reset_n,
   vga_focus_metric_if.slave   vga,
   input  logic                iPeak_clear,
   output logic [ACC_W-1:0]    oMetric,
   output logic                oMetric_valid,
   output logic [ACC_W-1:0]    oPeak,
   output logic                oOverrun
);

   localparam logic [ACC_W-1:0]   ACC_MAX = '1;
   // Window bounds expressed as offset + span so that a zero origin needs no
   // always-true comparison; the first window column is skipped since its left
   // neighbour lies outside the window.
   localparam logic [COORD_W-1:0] X_LO   = COORD_W'(WIN_X0 + 1);
   localparam logic [COORD_W-1:0] X_SPAN = COORD_W'(WIN_W - 1);
   localparam logic [COORD_W-1:0] Y_LO   = COORD_W'(WIN_Y0);
   localparam logic [COORD_W-1:0] Y_SPAN = COORD_W'(WIN_H);

   logic [7:0]         r_s1_gr;
   logic               r_s1_vs;
   logic               r_s1_blank_n;
   logic               r_vs_prev;
   logic [7:0]         r_prev_gr;
   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   r_metric;
   logic               r_metric_valid;
   logic [ACC_W-1:0]   r_peak;

   logic               w_vs_fall;
   logic [COORD_W-1:0] w_x;
   logic [COORD_W-1:0] w_y;
   logic [COORD_W-1:0] w_x_off;
   logic [COORD_W-1:0] w_y_off;
   logic               w_in_win;
   logic               w_overrun;
   logic signed [8:0]  w_diff_s;
   logic signed [8:0]  w_diff_neg;
   logic [7:0]         w_diff;
   logic [ACC_W-1:0]   w_acc_next;
   logic [ACC_W-1:0]   w_peak_base;

   // Input stage: every decision below works on these registered copies.
   always_ff @(posedge VGA_CLK) begin
      if (!reset_n) begin
         r_s1_gr      <= '0;
         r_s1_vs      <= 1'b0;
         r_s1_blank_n <= 1'b0;
         r_vs_prev    <= 1'b0;
      end else begin
         r_s1_gr      <= vga.iVGA_Gr;
         r_s1_vs      <= vga.iVGA_VS;
         r_s1_blank_n <= vga.iVGA_BLANK_N;
         r_vs_prev    <= r_s1_vs;
      end
   end

   assign w_vs_fall = r_vs_prev & ~r_s1_vs;

   vga_pixel_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_counter (
      .VGA_CLK   (VGA_CLK),
      .reset_n   (reset_n),
      .i_blank_n (r_s1_blank_n),
      .i_vs      (r_s1_vs),
      .o_x       (w_x),
      .o_y       (w_y),
      .o_overrun (w_overrun)
   );

   assign w_x_off  = w_x - X_LO;
   assign w_y_off  = w_y - Y_LO;
   assign w_in_win = r_s1_blank_n && (w_x_off < X_SPAN) && (w_y_off < Y_SPAN);

   assign w_diff_s   = $signed({1'b0, r_s1_gr}) - $signed({1'b0, r_prev_gr});
   assign w_diff_neg = -w_diff_s;
   assign w_diff     = w_diff_s[8] ? w_diff_neg[7:0] : w_diff_s[7:0];
   assign w_acc_next = ACC_W'(sat_add(SUM_W'(r_acc), w_diff, SUM_W'(ACC_MAX)));

   // A clear in the same cycle as a report takes effect first.
   assign w_peak_base = iPeak_clear ? '0 : r_peak;

   // Left-neighbour pixel; follows every active pixel, including ones outside the window.
   always_ff @(posedge VGA_CLK) begin
      if (!reset_n) begin
         r_prev_gr <= '0;
      end else if (r_s1_blank_n) begin
         r_prev_gr <= r_s1_gr;
      end
   end

   // Frame FSM: accumulate in the window, report and restart at every vsync fall.
   always_ff @(posedge VGA_CLK) begin
      if (!reset_n) begin
         r_state        <= S_SYNC;
         r_acc          <= '0;
         r_metric       <= '0;
         r_metric_valid <= 1'b0;
         r_peak         <= '0;
      end else begin
         r_metric_valid <= 1'b0;
         if (iPeak_clear) begin
            r_peak <= '0;
         end
         case (r_state)
            S_SYNC: begin
               // The frame in progress at reset is incomplete, so nothing is measured until
               // the next boundary.
               r_acc <= '0;
               if (w_vs_fall) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_vs_fall) begin
                  r_metric       <= r_acc;
                  r_metric_valid <= 1'b1;
                  r_acc          <= '0;
                  if (r_acc > w_peak_base) begin
                     r_peak <= r_acc;
                  end
               end else if (w_in_win) begin
                  r_acc <= w_acc_next;
               end
            end
            default: begin
               r_state <= S_SYNC;
               r_acc   <= '0;
            end
         endcase
      end
   end

   assign oMetric       = r_metric;
   assign oMetric_valid = r_metric_valid;
   assign oPeak         = r_peak;
   assign oOverrun      = w_overrun;

endmodule

// File: tb/tb_vga_focus_metric.sv
// Bench for vga_focus_metric: three instances (full window, 12-bit accumulator, small
// window) share one 10x10 video stream; frames are described in a table, reports are
// matched against a per-instance scoreboard queue.
module tb_vga_focus_metric;

   logic        VGA_CLK;
   logic        reset_n;
   logic        iPeak_clear;

   logic [31:0] metric0, peak0;
   logic        valid0, ovr0;
   logic [11:0] metric1, peak1;
   logic        valid1, ovr1;
   logic [31:0] metric2, peak2;
   logic        valid2, ovr2;

   vga_focus_metric_if vga_bus ();

   vga_focus_metric #(
      .WIDTH(10), .HEIGHT(10), .WIN_X0(0), .WIN_Y0(0), .WIN_W(10), .WIN_H(10), .ACC_W(32)
   ) dut_full (
      .VGA_CLK(VGA_CLK), .reset_n(reset_n), .vga(vga_bus), .iPeak_clear(iPeak_clear),
      .oMetric(metric0), .oMetric_valid(valid0), .oPeak(peak0), .oOverrun(ovr0)
   );

   vga_focus_metric #(
      .WIDTH(10), .HEIGHT(10), .WIN_X0(0), .WIN_Y0(0), .WIN_W(10), .WIN_H(10), .ACC_W(12)
   ) dut_sat (
      .VGA_CLK(VGA_CLK), .reset_n(reset_n), .vga(vga_bus), .iPeak_clear(iPeak_clear),
      .oMetric(metric1), .oMetric_valid(valid1), .oPeak(peak1), .oOverrun(ovr1)
   );

   vga_focus_metric #(
      .WIDTH(10), .HEIGHT(10), .WIN_X0(2), .WIN_Y0(3), .WIN_W(4), .WIN_H(2), .ACC_W(32)
   ) dut_win (
      .VGA_CLK(VGA_CLK), .reset_n(reset_n), .vga(vga_bus), .iPeak_clear(iPeak_clear),
      .oMetric(metric2), .oMetric_valid(valid2), .oPeak(peak2), .oOverrun(ovr2)
   );

   initial VGA_CLK = 1'b0;
   always #20 VGA_CLK = ~VGA_CLK;

   // ---------------------------------------------------------------- bookkeeping
   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic [31:0] metric;
      logic [31:0] peak;
   } exp_t;

   exp_t exp_q [3][$];
   logic prev_valid [3];

   typedef struct packed {
      logic [1:0]       pattern;   // 0 ramp, 1 column checker, 2 ramp inside small window
      logic             clr_rep;   // iPeak_clear in the report cycle
      logic             long_line; // line 2 carries 12 active pixels
      logic             mid_clr;   // iPeak_clear pulse mid-frame
      logic             mid_rst;   // reset_n low 5 cycles mid-frame
      logic             report;    // a report is expected at this frame's end
      logic [2:0][31:0] metric;
      logic [2:0][31:0] peak;
      logic             ovr_end;
   } frame_vec_t;

   localparam int N_FRAMES = 10;
   frame_vec_t vecs [N_FRAMES];

   task automatic check(input string name, input int idx,
                        input longint unsigned act, input longint unsigned exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s[dut%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [1:0] pat, input logic clr_rep,
                          input logic long_line, input logic mid_clr, input logic mid_rst,
                          input logic report, input int m0, input int m1, input int m2,
                          input int p0, input int p1, input int p2, input logic ovr);
      vecs[i].pattern   = pat;
      vecs[i].clr_rep   = clr_rep;
      vecs[i].long_line = long_line;
      vecs[i].mid_clr   = mid_clr;
      vecs[i].mid_rst   = mid_rst;
      vecs[i].report    = report;
      vecs[i].metric[0] = 32'(m0);
      vecs[i].metric[1] = 32'(m1);
      vecs[i].metric[2] = 32'(m2);
      vecs[i].peak[0]   = 32'(p0);
      vecs[i].peak[1]   = 32'(p1);
      vecs[i].peak[2]   = 32'(p2);
      vecs[i].ovr_end   = ovr;
   endtask

   function automatic logic [7:0] pix(input logic [1:0] pat, input int line, input int p);
      case (pat)
         2'd0:    return 8'(p);
         2'd1:    return (p % 2 == 1) ? 8'd255 : 8'd0;
         default: return (line >= 3 && line <= 4 && p >= 2 && p <= 5) ? 8'(p) : 8'd255;
      endcase
   endfunction

   // One input cycle: apply, let the edge sample it, settle 1 time unit.
   task automatic drive(input logic [7:0] gr, input logic vs, input logic blank_n);
      vga_bus.iVGA_Gr      = gr;
      vga_bus.iVGA_VS      = vs;
      vga_bus.iVGA_BLANK_N = blank_n;
      @(posedge VGA_CLK);
      #1;
   endtask

   // ---------------------------------------------------------------- report monitor
   task automatic check_report(input int idx, input logic v,
                               input logic [31:0] m, input logic [31:0] p);
      exp_t e;
      if (v) begin
         check("pulse_width", idx, 64'(prev_valid[idx]), 0);
         if (exp_q[idx].size() == 0) begin
            check("report_expected", idx, 0, 1);
         end else begin
            e = exp_q[idx].pop_front();
            check("metric", idx, 64'(m), 64'(e.metric));
            check("peak_at_report", idx, 64'(p), 64'(e.peak));
            $display("report dut%0d: metric=%0d peak=%0d", idx, m, p);
         end
      end
      prev_valid[idx] = v;
   endtask

   always @(negedge VGA_CLK) begin
      check_report(0, valid0, metric0, peak0);
      check_report(1, valid1, 32'(metric1), 32'(peak1));
      check_report(2, valid2, metric2, peak2);
   end

   // ---------------------------------------------------------------- frame driver
   task automatic run_frame(input int f);
      frame_vec_t v;
      exp_t       e;
      int         npix;
      v = vecs[f];
      if (v.report) begin
         for (int d = 0; d < 3; d++) begin
            e.metric = v.metric[d];
            e.peak   = v.peak[d];
            exp_q[d].push_back(e);
         end
      end
      for (int line = 0; line < 10; line++) begin
         npix = (v.long_line && line == 2) ? 12 : 10;
         for (int p = 0; p < npix; p++) begin
            reset_n     = !(v.mid_rst && line == 4 && p >= 3 && p < 8);
            iPeak_clear = v.mid_clr && line == 5 && p == 0;
            drive(pix(v.pattern, line, p), 1'b1, 1'b1);
            if (iPeak_clear) begin
               check("mid_clear_peak", 0, 64'(peak0), 0);
               check("mid_clear_peak", 1, 64'(peak1), 0);
               check("mid_clear_peak", 2, 64'(peak2), 0);
            end
            if (!reset_n) begin
               check("reset_outputs", 0, 64'(metric0 | peak0 | 32'(valid0) | 32'(ovr0)), 0);
               check("reset_outputs", 1, 64'(metric1 | peak1 | 12'(valid1) | 12'(ovr1)), 0);
               check("reset_outputs", 2, 64'(metric2 | peak2 | 32'(valid2) | 32'(ovr2)), 0);
            end
         end
         iPeak_clear = 1'b0;
         reset_n     = 1'b1;
         for (int h = 0; h < 4; h++) drive(8'd0, 1'b1, 1'b0);
         if (v.long_line && line == 2) begin
            check("overrun_set", 0, 64'(ovr0), 1);
         end
      end
      // vertical blank: 2 idle, 3 with vsync low, 2 idle
      drive(8'd0, 1'b1, 1'b0);
      drive(8'd0, 1'b1, 1'b0);
      drive(8'd0, 1'b0, 1'b0);
      check("no_early_report", 0, 64'(valid0), 0);
      iPeak_clear = v.clr_rep;
      drive(8'd0, 1'b0, 1'b0);
      iPeak_clear = 1'b0;
      check("report_latency", 0, 64'(valid0), 64'(v.report));
      drive(8'd0, 1'b0, 1'b0);
      drive(8'd0, 1'b1, 1'b0);
      drive(8'd0, 1'b1, 1'b0);
      check("overrun_end", 0, 64'(ovr0), 64'(v.ovr_end));
      $display("frame %0d done: pattern=%0d report=%0b overrun=%0b", f, v.pattern, v.report, ovr0);
   endtask

   // ---------------------------------------------------------------- test sequence
   initial begin
      //          i pat clr long mclr mrst rep  full   sat   win   pfull  psat  pwin ovr
      set_vec(0, 2'd0, 0, 0, 0, 0, 0,     0,    0,    0,     0,    0,    0, 0);
      set_vec(1, 2'd0, 0, 0, 0, 0, 1,    90,   90,    6,    90,   90,    6, 0);
      set_vec(2, 2'd1, 0, 0, 0, 0, 1, 22950, 4095, 1530, 22950, 4095, 1530, 0);
      set_vec(3, 2'd0, 0, 0, 0, 0, 1,    90,   90,    6, 22950, 4095, 1530, 0);
      set_vec(4, 2'd0, 1, 0, 0, 0, 1,    90,   90,    6,    90,   90,    6, 0);
      set_vec(5, 2'd2, 0, 0, 0, 0, 1,  1012, 1012,    6,  1012, 1012,    6, 0);
      set_vec(6, 2'd0, 0, 1, 1, 0, 1,    90,   90,    6,    90,   90,    6, 1);
      set_vec(7, 2'd0, 0, 0, 0, 0, 1,    90,   90,    6,    90,   90,    6, 1);
      set_vec(8, 2'd0, 0, 0, 0, 1, 0,     0,    0,    0,     0,    0,    0, 0);
      set_vec(9, 2'd0, 0, 0, 0, 0, 1,    90,   90,    6,    90,   90,    6, 0);

      for (int d = 0; d < 3; d++) prev_valid[d] = 1'b0;
      reset_n     = 1'b0;
      iPeak_clear = 1'b0;
      for (int c = 0; c < 3; c++) drive(8'd0, 1'b1, 1'b0);
      check("reset_state", 0, 64'(metric0 | peak0 | 32'(valid0) | 32'(ovr0)), 0);
      check("reset_state", 1, 64'(metric1 | peak1 | 12'(valid1) | 12'(ovr1)), 0);
      check("reset_state", 2, 64'(metric2 | peak2 | 32'(valid2) | 32'(ovr2)), 0);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) drive(8'd0, 1'b1, 1'b0);

      for (int f = 0; f < N_FRAMES; f++) begin
         run_frame(f);
      end

      for (int c = 0; c < 5; c++) drive(8'd0, 1'b1, 1'b0);
      for (int d = 0; d < 3; d++) begin
         check("missing_reports", d, 64'(exp_q[d].size()), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
